mem_arbiter: RTL and testbench

Two-port arbiter that shares one unified memory port between the instruction-fetch path and the load/store unit of the pipelined RISC-V core. It sits between the fetch stage / LSU and a single-ported, variable-latency memory. It keeps one transaction outstanding at a time and gives the LSU priority. A starvation counter guarantees fetch forward progress. All memory-side request outputs are registered.

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters (fetch, LSU) and the shared memory port.
// master: the arbiter's view. slave: the requester/memory side that drives the arbiter inputs.
interface mem_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  localparam int unsigned MASK_W = 4;

  // Fetch path
  logic              if_req_i;
  logic [AW-1:0]     if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DW-1:0]     if_rdata_o;
  logic              stall_f_o;

  // Load/store path
  logic              ls_req_i;
  logic              ls_we_i;
  logic [MASK_W-1:0] ls_mask_i;
  logic [AW-1:0]     ls_addr_i;
  logic [DW-1:0]     ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DW-1:0]     ls_rdata_o;

  // Shared memory port
  logic              mem_req_o;
  logic              mem_we_o;
  logic [MASK_W-1:0] mem_mask_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DW-1:0]     mem_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, stall_f_o,
    input  ls_req_i, ls_we_i, ls_mask_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, stall_f_o,
    output ls_req_i, ls_we_i, ls_mask_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between instruction fetch
// and the LSU. One transaction in flight, LSU priority, starvation counter for fetch.
// Optional macro ARB_PERF_EN adds conflict_cnt_o, a wrapping count of contested arbitrations.
module mem_arbiter #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.master bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   conflict_cnt_o
`endif
);

  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic              we;
    logic [MASK_W-1:0] mask;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
  } mem_cmd_t;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;      // 0 = fetch, 1 = LSU
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             req_q, req_d;
  mem_cmd_t         cmd_q, cmd_d;

  logic in_req, in_rsp, gnt_hit, rsp_hit, arb_en;
  logic if_cand, ls_cand, both, if_win, ls_win;

  // Handshake qualification; the owner's still-held request is masked while it awaits its grant
  assign in_req  = (state_q == REQ);
  assign in_rsp  = (state_q == RSP);
  assign gnt_hit = in_req & bus.mem_gnt_i;
  assign rsp_hit = (in_rsp | gnt_hit) & bus.mem_rvalid_i;
  assign arb_en  = (state_q == IDLE) | rsp_hit;
  assign if_cand = bus.if_req_i & ~(in_req & ~owner_q);
  assign ls_cand = bus.ls_req_i & ~(in_req & owner_q);
  assign both    = if_cand & ls_cand;
  assign if_win  = if_cand & (~ls_cand | (starve_q == STARVE_MAX));
  assign ls_win  = ls_cand & ~if_win;

  // Responses routed to the owner only; gated by registered state
  assign bus.if_gnt_o    = gnt_hit & ~owner_q;
  assign bus.ls_gnt_o    = gnt_hit & owner_q;
  assign bus.if_rvalid_o = rsp_hit & ~owner_q;
  assign bus.ls_rvalid_o = rsp_hit & owner_q;
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.ls_rdata_o  = bus.mem_rdata_i;
  assign bus.stall_f_o   = bus.if_req_i & ~(gnt_hit & ~owner_q);

  // Memory request outputs come straight from flops
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = cmd_q.we;
  assign bus.mem_mask_o  = cmd_q.mask;
  assign bus.mem_addr_o  = cmd_q.addr;
  assign bus.mem_wdata_o = cmd_q.wdata;

  // Next-state, arbitration, payload capture and starvation tracking
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    cmd_d    = cmd_q;
    req_d    = 1'b0;

    case (state_q)
      REQ:       if (gnt_hit) state_d = RSP;
      IDLE, RSP: state_d = state_q;
      default:   state_d = IDLE;
    endcase

    if (arb_en) begin
      state_d = IDLE;
      if (if_win) begin
        state_d     = REQ;
        owner_d     = 1'b0;
        starve_d    = '0;
        cmd_d.we    = 1'b0;
        cmd_d.mask  = MASK_W'(4'hF);
        cmd_d.addr  = bus.if_addr_i;
        cmd_d.wdata = '0;
      end else if (ls_win) begin
        state_d     = REQ;
        owner_d     = 1'b1;
        cmd_d.we    = bus.ls_we_i;
        cmd_d.mask  = bus.ls_mask_i;
        cmd_d.addr  = bus.ls_addr_i;
        cmd_d.wdata = bus.ls_wdata_i;
        if (both && (starve_q < STARVE_MAX)) starve_d = starve_q + CNT_W'(1);
      end
    end

    req_d = (state_d == REQ);
  end

  // State and registered memory-side outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      req_q    <= 1'b0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      req_q    <= req_d;
      cmd_q    <= cmd_d;
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] conflict_q;

  // Count contested arbitrations, wrapping naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) conflict_q <= '0;
    else if (arb_en && both) conflict_q <= conflict_q + 32'd1;
  end

  assign conflict_cnt_o = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays fetch, LSU and memory; expected grants
// and responses are queued as stimulus is driven and retired by a negedge monitor.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.DW(32), .AW(32)) bus ();

`ifdef ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  mem_arbiter #(.DW(32), .AW(32), .STARVE_LIMIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef ARB_PERF_EN
    ,
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  typedef struct {
    logic        ls;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_gnt_t;

  typedef struct {
    logic        ls;
    logic [31:0] data;
  } exp_rsp_t;

  exp_gnt_t gnt_q[$];
  exp_rsp_t rsp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Scoreboard monitor: every grant / response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && (bus.if_gnt_o || bus.ls_gnt_o)) begin
      checks++;
      if (gnt_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt if=%0b ls=%0b", bus.if_gnt_o, bus.ls_gnt_o);
      end else begin
        exp_gnt_t e;
        e = gnt_q.pop_front();
        if ({bus.ls_gnt_o, bus.if_gnt_o} !== {e.ls, ~e.ls}) begin
          errors++;
          $display("FAIL gnt_side got ls=%0b if=%0b want ls=%0b", bus.ls_gnt_o, bus.if_gnt_o, e.ls);
        end
        checks++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o} !==
            {1'b1, e.we, e.mask, e.addr}) begin
          errors++;
          $display("FAIL gnt_payload got req=%0b we=%0b mask=%h addr=%h want req=1 we=%0b mask=%h addr=%h",
                   bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o, e.we, e.mask, e.addr);
        end
        if (e.ls && e.we) begin
          checks++;
          if (bus.mem_wdata_o !== e.wdata) begin
            errors++;
            $display("FAIL gnt_wdata got %h want %h", bus.mem_wdata_o, e.wdata);
          end
        end
      end
    end
    if (!rst && (bus.if_rvalid_o || bus.ls_rvalid_o)) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid if=%0b ls=%0b", bus.if_rvalid_o, bus.ls_rvalid_o);
      end else begin
        exp_rsp_t r;
        r = rsp_q.pop_front();
        if ({bus.ls_rvalid_o, bus.if_rvalid_o} !== {r.ls, ~r.ls}) begin
          errors++;
          $display("FAIL rvalid_side got ls=%0b if=%0b want ls=%0b", bus.ls_rvalid_o, bus.if_rvalid_o, r.ls);
        end
        checks++;
        if ((r.ls ? bus.ls_rdata_o : bus.if_rdata_o) !== r.data) begin
          errors++;
          $display("FAIL rdata got if=%h ls=%h want %h", bus.if_rdata_o, bus.ls_rdata_o, r.data);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push_if(input logic [31:0] addr);
    exp_gnt_t e;
    e.ls = 1'b0; e.we = 1'b0; e.mask = 4'hF; e.addr = addr; e.wdata = 32'h0;
    gnt_q.push_back(e);
  endtask

  task automatic push_ls(input logic we, input logic [3:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata);
    exp_gnt_t e;
    e.ls = 1'b1; e.we = we; e.mask = mask; e.addr = addr; e.wdata = wdata;
    gnt_q.push_back(e);
  endtask

  task automatic push_rsp(input logic ls, input logic [31:0] data);
    exp_rsp_t r;
    r.ls = ls; r.data = data;
    rsp_q.push_back(r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_mask_i = '0; bus.ls_addr_i = '0; bus.ls_wdata_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    nxt(); nxt();
    neg();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_mem got req=%0b we=%0b mask=%h addr=%h wdata=%h want all 0",
               bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    checks++;
    if ({bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o, bus.stall_f_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b want 00000",
               {bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o, bus.stall_f_o});
    end
    checks++;
    if (dut.starve_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_starve got %0d want 0", dut.starve_q);
    end
`ifdef ARB_PERF_EN
    checks++;
    if (conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_conflict got %0d want 0", conflict_cnt);
    end
`endif
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
    push_if(32'h40);
    neg();
    checks++;
    if ({bus.mem_req_o, bus.stall_f_o} !== 2'b01) begin
      errors++;
      $display("FAIL fetch_c0 got req=%0b stall=%0b want req=0 stall=1", bus.mem_req_o, bus.stall_f_o);
    end
    nxt();
    bus.mem_gnt_i = 1'b1;
    neg();
    checks++;
    if ({bus.mem_req_o, bus.if_gnt_o, bus.stall_f_o} !== 3'b110) begin
      errors++;
      $display("FAIL fetch_c1 got req=%0b gnt=%0b stall=%0b want 1 1 0",
               bus.mem_req_o, bus.if_gnt_o, bus.stall_f_o);
    end
    nxt();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h00500093;
    push_rsp(1'b0, 32'h00500093);
    neg();
    checks++;
    if ({bus.mem_req_o, bus.if_rvalid_o, bus.ls_rvalid_o} !== 3'b010) begin
      errors++;
      $display("FAIL fetch_c2 got req=%0b if_rv=%0b ls_rv=%0b want 0 1 0",
               bus.mem_req_o, bus.if_rvalid_o, bus.ls_rvalid_o);
    end
    nxt();
    bus.mem_rvalid_i = 1'b0;
    neg();
    checks++;
    if (bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle got req=%0b want 0", bus.mem_req_o);
    end
    nxt();
  endtask

  task automatic test_conflict();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_mask_i = 4'b0011;
    bus.ls_addr_i = 32'h100; bus.ls_wdata_i = 32'hDEADBEEF;
    push_ls(1'b1, 4'b0011, 32'h100, 32'hDEADBEEF);
    push_if(32'h80);
    nxt();
    bus.mem_gnt_i = 1'b1;
    neg();
    checks++;
    if (dut.starve_q !== 4'd1) begin
      errors++;
      $display("FAIL conflict_starve1 got %0d want 1", dut.starve_q);
    end
    nxt();
    bus.ls_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0;
    push_rsp(1'b1, 32'h0);
    neg();
    checks++;
    if (bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL conflict_rsp_req got %0b want 0", bus.mem_req_o);
    end
    nxt();
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    neg();
    checks++;
    if ({bus.mem_req_o, bus.mem_addr_o, dut.starve_q} !== {1'b1, 32'h80, 4'd0}) begin
      errors++;
      $display("FAIL conflict_if_next got req=%0b addr=%h starve=%0d want 1 00000080 0",
               bus.mem_req_o, bus.mem_addr_o, dut.starve_q);
    end
    nxt();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h13;
    push_rsp(1'b0, 32'h13);
    neg();
    nxt();
    bus.mem_rvalid_i = 1'b0;
    nxt();
  endtask

  task automatic test_starvation();
    logic        order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef ARB_PERF_EN
    logic [31:0] cc0;
    cc0 = conflict_cnt;
`endif
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_mask_i = 4'hF; bus.ls_addr_i = 32'h200;
    bus.ls_wdata_i = 32'h0;
    for (int t = 0; t < 6; t++) begin
      if (order[t]) push_ls(1'b0, 4'hF, 32'h200, 32'h0);
      else push_if(32'h300);
    end
    neg();
    for (int t = 0; t < 6; t++) begin
      nxt();
      bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b0;
      neg();
      checks++;
      if ({bus.ls_gnt_o, bus.if_gnt_o} !== {order[t], ~order[t]}) begin
        errors++;
        $display("FAIL starve_order t=%0d got ls=%0b if=%0b want ls=%0b",
                 t, bus.ls_gnt_o, bus.if_gnt_o, order[t]);
      end
      nxt();
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'(t + 100);
      push_rsp(order[t], 32'(t + 100));
      if (t == 5) begin
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
      end
      neg();
    end
    nxt();
    bus.mem_rvalid_i = 1'b0;
    neg();
    checks++;
    if ({bus.mem_req_o, dut.starve_q} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL starve_end got req=%0b starve=%0d want 0 1", bus.mem_req_o, dut.starve_q);
    end
`ifdef ARB_PERF_EN
    checks++;
    if (conflict_cnt - cc0 !== 32'd6) begin
      errors++;
      $display("FAIL starve_conflicts got %0d want 6", conflict_cnt - cc0);
    end
`endif
    nxt();
  endtask

  task automatic test_stall();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h500;
    push_if(32'h500);
    nxt();
    bus.if_addr_i = 32'hFFFF_0000;
    for (int c = 0; c < 5; c++) begin
      neg();
      checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o, bus.stall_f_o, bus.if_gnt_o} !==
          {1'b1, 1'b0, 4'hF, 32'h500, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_c%0d got req=%0b we=%0b mask=%h addr=%h stall=%0b gnt=%0b want 1 0 f 00000500 1 0",
                 c, bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o, bus.stall_f_o, bus.if_gnt_o);
      end
      nxt();
    end
    bus.mem_gnt_i = 1'b1;
    neg();
    checks++;
    if (bus.stall_f_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got %0b want 0", bus.stall_f_o);
    end
    nxt();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0513;
    push_rsp(1'b0, 32'h0000_0513);
    neg();
    nxt();
    bus.mem_rvalid_i = 1'b0;
    nxt();
  endtask

  task automatic test_back_to_back();
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_mask_i = 4'b1100; bus.ls_addr_i = 32'h600;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h700;
    push_ls(1'b0, 4'b1100, 32'h600, 32'h0);
    push_if(32'h700);
    nxt();
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hA5;
    push_rsp(1'b1, 32'hA5);
    neg();
    checks++;
    if ({bus.ls_gnt_o, bus.ls_rvalid_o} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_zero_lat got gnt=%0b rv=%0b want 1 1", bus.ls_gnt_o, bus.ls_rvalid_o);
    end
    nxt();
    bus.ls_req_i = 1'b0; bus.mem_rdata_i = 32'h5A;
    push_rsp(1'b0, 32'h5A);
    neg();
    checks++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h700}) begin
      errors++;
      $display("FAIL b2b_no_bubble got req=%0b addr=%h want 1 00000700", bus.mem_req_o, bus.mem_addr_o);
    end
    nxt();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    neg();
    checks++;
    if (bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got req=%0b want 0", bus.mem_req_o);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h900;
    push_if(32'h900);
    nxt();
    bus.mem_gnt_i = 1'b1;
    nxt();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD;
    neg();
    checks++;
    if ({bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_gnt_o, bus.ls_gnt_o} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_pulses got %b want 0000",
               {bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_gnt_o, bus.ls_gnt_o});
    end
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_mem got req=%0b we=%0b mask=%h addr=%h wdata=%h want all 0",
               bus.mem_req_o, bus.mem_we_o, bus.mem_mask_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
`ifdef ARB_PERF_EN
    checks++;
    if (conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_conflict got %0d want 0", conflict_cnt);
    end
`endif
    nxt();
    bus.mem_rvalid_i = 1'b0;
    nxt();
  endtask

  task automatic test_drain();
    checks++;
    if (gnt_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got gnt_left=%0d rsp_left=%0d want 0 0", gnt_q.size(), rsp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_starvation();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
